mem_port_arbiter: RTL and testbench

- Shares the single data-memory port between the two EX/MEM lanes of the dual-issue pipeline. Lane 0 is the older instruction in program order.
- When both lanes access memory in the same cycle, the block serializes them over two cycles. During the first cycle it asserts stall, which freezes IF through EX/MEM.
- Returns load data per lane to the MEM/WB registers.
- Counts the stall cycles it inserts, for performance monitoring.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_sat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and default widths for the data-memory port arbiter
//
// Contents:
//   arb_state_t    : arbiter FSM state (IDLE = 1'b0, SECOND = 1'b1)
//   MEM_ADDR_W_DEF : default memory address width, shared with the EX/MEM register
//   MEM_DATA_W_DEF : default memory data width, shared with the EX/MEM register
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } arb_state_t;

    localparam int MEM_ADDR_W_DEF = 32;
    localparam int MEM_DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// rtl/mem_port_arbiter_sat_counter.sv - saturating incrementer with synchronous active-low clear
//
// Module sat_counter
// Parameters:
//   W   : counter width
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low clear
//   inc : add one this cycle (ignored once the count is all-ones)
//   cnt : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory port between the two dual-issue EX/MEM lanes
//
// Optional feature macro: MEM_ARB_READ_PAIR_EN
//   defined     : two reads to the same address in one cycle are served together, no stall
//   not defined : every paired access is serialized over two cycles
//
// Parameters:
//   ADDR_W, DATA_W : memory address / data width
//   CNT_W          : width of the saturating stall counter
// Ports:
//   clk, rst                         : clock, synchronous active-low reset
//   rd_en0/wr_en0/addr0/wdata0       : lane 0 (older instruction) request
//   rd_en1/wr_en1/addr1/wdata1       : lane 1 (younger instruction) request
//   mem_addr/mem_wdata/mem_re/mem_we : memory port request
//   mem_rdata                        : asynchronous memory read data
//   rdata0/rdata1                    : per-lane load result to MEM/WB
//   stall                            : freezes PC, IF/ID, ID/EX and EX/MEM
//   stall_cnt                        : number of stall cycles inserted
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W_DEF,
    parameter int DATA_W = MEM_DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en0,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              rd_en1,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    arb_state_t        state_q;
    arb_state_t        eff_state;
    logic [DATA_W-1:0] hold_q;
    logic              acc0;
    logic              acc1;
    logic              pair_read;
    logic              serve0;
    logic              serve1;

    assign acc0 = rd_en0 | wr_en0;
    assign acc1 = rd_en1 | wr_en1;

    // While reset is asserted the port already behaves as in IDLE, so a
    // pending second-half access (lane 1) is never issued in the reset cycle.
    assign eff_state = rst ? state_q : IDLE;

`ifdef MEM_ARB_READ_PAIR_EN
    assign pair_read = rd_en0 & rd_en1 & ~wr_en0 & ~wr_en1 & (addr0 == addr1);
`else
    assign pair_read = 1'b0;
`endif

    // A same-address read pair rides on lane 0's access; both lanes take mem_rdata.
    assign stall  = (eff_state == IDLE) & acc0 & acc1 & ~pair_read;
    assign serve0 = (eff_state == IDLE) & acc0;
    assign serve1 = ((eff_state == IDLE) & ~acc0 & acc1) | ((eff_state == SECOND) & acc1);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (serve0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = wr_en0;
            mem_re    = rd_en0 & ~wr_en0;
        end else if (serve1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = wr_en1;
            mem_re    = rd_en1 & ~wr_en1;
        end
    end

    assign rdata0 = (eff_state == SECOND) ? hold_q : mem_rdata;
    assign rdata1 = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall) begin
                        hold_q  <= mem_rdata;
                        state_q <= SECOND;
                    end
                end
                SECOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        rd_en0, wr_en0, rd_en1, wr_en1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic [31:0] rdata0, rdata1;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [31:0] mem [0:255];
    int          cyc;
    int          lane0_wr40;
    int          checks;
    int          errors;
    logic        exp_pair_stall;
    logic [15:0] exp_pair_cnt;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en0    (rd_en0),
        .wr_en0    (wr_en0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .rd_en1    (rd_en1),
        .wr_en1    (wr_en1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    // Memory model: preload on the first edge, then commit writes on mem_we.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hA5A5A5A5;
            mem[8'h34] <= 32'h5A5A5A5A;
            mem[8'h50] <= 32'h12345678;
            mem[8'h64] <= 32'hCAFE0000;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_addr == 32'h40 && mem_wdata == 32'h1) lane0_wr40 <= lane0_wr40 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en0 = 0; wr_en0 = 0; addr0 = 0; wdata0 = 0;
        rd_en1 = 0; wr_en1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc = 0;
        lane0_wr40 = 0;
        checks = 0;
        errors = 0;
`ifdef MEM_ARB_READ_PAIR_EN
        exp_pair_stall = 1'b0;
        exp_pair_cnt   = 16'd0;
`else
        exp_pair_stall = 1'b1;
        exp_pair_cnt   = 16'd1;
`endif
        rst = 0;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_re", {31'b0, mem_re}, 32'h0);
        chk("reset_we", {31'b0, mem_we}, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_cnt", {16'b0, stall_cnt}, 32'h0);
        next_cycle();
        rst = 1;

        // single lane 0 load
        rd_en0 = 1; addr0 = 32'h10;
        @(negedge clk);
        chk("single_rdata0", rdata0, 32'hDEADBEEF);
        chk("single_stall", {31'b0, stall}, 32'h0);
        chk("single_re", {31'b0, mem_re}, 32'h1);
        chk("single_cnt", {16'b0, stall_cnt}, 32'h0);
        next_cycle();

        // lane 0 store then lane 1 load, same address
        wr_en0 = 1; rd_en0 = 0; addr0 = 32'h20; wdata0 = 32'h11111111;
        rd_en1 = 1; addr1 = 32'h20;
        @(negedge clk);
        chk("st_ld_c1_stall", {31'b0, stall}, 32'h1);
        chk("st_ld_c1_we", {31'b0, mem_we}, 32'h1);
        chk("st_ld_c1_addr", mem_addr, 32'h20);
        next_cycle();
        @(negedge clk);
        chk("st_ld_c2_stall", {31'b0, stall}, 32'h0);
        chk("st_ld_c2_we", {31'b0, mem_we}, 32'h0);
        chk("st_ld_c2_rdata1", rdata1, 32'h11111111);
        chk("st_ld_c2_cnt", {16'b0, stall_cnt}, 32'h1);
        next_cycle();
        idle_inputs();

        // paired loads, different addresses
        rd_en0 = 1; addr0 = 32'h30; rd_en1 = 1; addr1 = 32'h34;
        @(negedge clk);
        chk("ld_ld_c1_stall", {31'b0, stall}, 32'h1);
        chk("ld_ld_c1_we", {31'b0, mem_we}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("ld_ld_c2_stall", {31'b0, stall}, 32'h0);
        chk("ld_ld_c2_rdata0", rdata0, 32'hA5A5A5A5);
        chk("ld_ld_c2_rdata1", rdata1, 32'h5A5A5A5A);
        chk("ld_ld_c2_cnt", {16'b0, stall_cnt}, 32'h2);
        next_cycle();
        idle_inputs();

        // paired stores, same address: lane 1 wins, lane 0 writes once
        wr_en0 = 1; addr0 = 32'h40; wdata0 = 32'h1;
        wr_en1 = 1; addr1 = 32'h40; wdata1 = 32'h2;
        @(negedge clk);
        chk("st_st_c1_stall", {31'b0, stall}, 32'h1);
        next_cycle();
        @(negedge clk);
        chk("st_st_c2_wdata", mem_wdata, 32'h2);
        chk("st_st_c2_we", {31'b0, mem_we}, 32'h1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("st_st_mem", mem[8'h40], 32'h2);
        chk("st_st_lane0_once", lane0_wr40, 32'h1);
        chk("st_st_cnt", {16'b0, stall_cnt}, 32'h3);
        next_cycle();

        // reset while in SECOND
        wr_en0 = 1; addr0 = 32'h60; wdata0 = 32'h77;
        wr_en1 = 1; addr1 = 32'h64; wdata1 = 32'h99;
        next_cycle();
        @(negedge clk);
        chk("rst2_pre_state", {31'b0, dut.state_q}, 32'h1);
        chk("rst2_pre_cnt", {16'b0, stall_cnt}, 32'h4);
        rst = 0;
        next_cycle();
        rst = 1;
        idle_inputs();
        @(negedge clk);
        chk("rst2_state", {31'b0, dut.state_q}, 32'h0);
        chk("rst2_hold", dut.hold_q, 32'h0);
        chk("rst2_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("rst2_no_lane1_wr", mem[8'h64], 32'hCAFE0000);
        next_cycle();

        // same-address read pair
        rd_en0 = 1; addr0 = 32'h50; rd_en1 = 1; addr1 = 32'h50;
        @(negedge clk);
        chk("rpair_stall", {31'b0, stall}, {31'b0, exp_pair_stall});
        chk("rpair_rdata0", rdata0, 32'h12345678);
        chk("rpair_rdata1", rdata1, 32'h12345678);
        next_cycle();
        @(negedge clk);
        chk("rpair_c2_stall", {31'b0, stall}, 32'h0);
        chk("rpair_cnt", {16'b0, stall_cnt}, {16'b0, exp_pair_cnt});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("end_idle_re", {31'b0, mem_re}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
